jk_reg_n: RTL and testbench
===========================

JK_REG_N -- requirements
Module: jk_reg_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning register width in bits; legal range 2..32.
REQ-002 The block SHALL have parameter RST_VAL, default 0, meaning the WIDTH-bit value loaded into q on reset.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port en  input  1  update enable; low means hold.
REQ-006 The block SHALL have port mode  input  2  operation select: 00 JK, 01 count, 10 shift, 11 load.
REQ-007 The block SHALL have port j  input  WIDTH  per-bit J inputs, used in JK mode.
REQ-008 The block SHALL have port k  input  WIDTH  per-bit K inputs, used in JK mode.
REQ-009 The block SHALL have port d  input  WIDTH  parallel load data.
REQ-010 The block SHALL have port dir  input  1  direction: 1 = up/left, 0 = down/right.
REQ-011 The block SHALL have port ser_in  input  1  serial input for shift mode.
REQ-012 The block SHALL have port q  output  WIDTH  registered state.
REQ-013 The block SHALL have port q_n  output  WIDTH  bitwise complement of q.
REQ-014 The block SHALL have port tc  output  1  terminal-count flag.
REQ-015 The block SHALL have port ser_out  output  1  serial output for shift mode.

Function
REQ-016 The block SHALL update q only on the rising edge of clk, with one-cycle latency from inputs to q.
REQ-017 When en is 0 and rst_n is 1, q SHALL hold its value, regardless of mode.
REQ-018 In mode 00, each bit i SHALL follow {j[i],k[i]}: 00 hold, 01 clear, 10 set, 11 toggle; bits are independent.
REQ-019 In mode 01 with dir=1, q SHALL increment by 1 modulo 2^WIDTH; the all-ones value wraps to 0.
REQ-020 In mode 01 with dir=0, q SHALL decrement by 1 modulo 2^WIDTH; 0 wraps to all-ones.
REQ-021 In mode 10 with dir=1, q SHALL become {q[WIDTH-2:0], ser_in} (shift left).
REQ-022 In mode 10 with dir=0, q SHALL become {ser_in, q[WIDTH-1:1]} (shift right).
REQ-023 In mode 11, q SHALL load d.
REQ-024 q_n SHALL be combinational ~q at all times, including during reset.
REQ-025 tc SHALL be combinational, and 1 only when en=1, mode=01, and either (dir=1 and q = all-ones) or (dir=0 and q = 0).
REQ-026 ser_out SHALL be combinational q[WIDTH-1] when dir=1, and q[0] when dir=0, in every mode.
REQ-027 A change of mode or dir between cycles SHALL take effect on the next edge with no pipeline flush or extra cycle.
REQ-028 The block SHALL contain no internal state other than q.

Reset
REQ-029 When rst_n=0 at a rising clk edge, q SHALL become RST_VAL, overriding en, mode and all data inputs.
REQ-030 rst_n low between edges SHALL NOT change q; the reset takes effect only at the next rising edge.
REQ-031 After reset, q_n SHALL be ~RST_VAL; tc and ser_out SHALL be derived from q=RST_VAL per REQ-025/026.
REQ-032 Reset asserted mid-count or mid-shift SHALL abandon the operation; the first enabled edge after release SHALL operate on RST_VAL.

Verification
REQ-033 JK mode check (WIDTH=8, q=8'hF0): j=8'hCC, k=8'hAA, en=1 -> after one edge q=8'h5C, matching hold/clear/set/toggle per bit.
REQ-034 Count-up wrap check (q=8'hFE, mode=01, dir=1): expect tc=0, then q=8'hFF with tc=1, then q=8'h00; for down-count from 8'h01, expect 8'h00 with tc=1, then 8'hFF.
REQ-035 Shift check (q=8'h81, mode=10): with dir=1 and ser_in=0, expect q=8'h02 and ser_out=1 before the edge; with dir=0 and ser_in=1, expect 8'hC0.
REQ-036 Synchronous reset check (RST_VAL=8'hA5): drop rst_n between edges -> q unchanged until the next edge, then 8'hA5 regardless of en/mode; after release, count-up gives 8'hA6.
REQ-037 Enable/load check: with en=0, mode=11, d=8'h3C -> q holds; with en=1 -> q=8'h3C and q_n=8'hC3 after one edge.

Source files
------------

// File: rtl/jk_reg_n.sv
// jk_reg_n: WIDTH-bit multi-function register.
// Modes: per-bit JK flip-flop, up/down counter, left/right shifter, parallel load.
// q is the only state; q_n, tc and ser_out are derived combinationally from q and the controls.
module jk_reg_n #(
    parameter int unsigned       WIDTH   = 8,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    input  logic             dir,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             tc,
    output logic             ser_out
);

    typedef enum logic [1:0] {
        MODE_JK    = 2'b00,
        MODE_COUNT = 2'b01,
        MODE_SHIFT = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    mode_t            op;
    logic [WIDTH-1:0] jk_next;
    logic [WIDTH-1:0] q_next;

    assign op = mode_t'(mode);

    // Per-bit JK behaviour: 00 hold, 01 clear, 10 set, 11 toggle.
    always_comb begin
        jk_next = q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            unique case ({j[i], k[i]})
                2'b00:   jk_next[i] = q[i];
                2'b01:   jk_next[i] = 1'b0;
                2'b10:   jk_next[i] = 1'b1;
                default: jk_next[i] = ~q[i];
            endcase
        end
    end

    // Next-state select for an enabled edge.
    always_comb begin
        q_next = q;
        unique case (op)
            MODE_JK:    q_next = jk_next;
            MODE_COUNT: q_next = dir ? (q + ONE) : (q - ONE);
            MODE_SHIFT: q_next = dir ? {q[WIDTH-2:0], ser_in} : {ser_in, q[WIDTH-1:1]};
            default:    q_next = d;
        endcase
    end

    // State register: synchronous active-low reset, then enable-gated update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= q_next;
        end
    end

    assign q_n     = ~q;
    assign tc      = en && (op == MODE_COUNT) && (dir ? (&q) : ~(|q));
    assign ser_out = dir ? q[WIDTH-1] : q[0];

endmodule

// File: tb/tb_jk_reg_n.sv
// Self-checking bench for jk_reg_n (WIDTH=8, RST_VAL=8'hA5).
// Directed vector table, hand-written reset sequences, then randomized traffic against a reference model.
module tb_jk_reg_n;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [7:0] j;
    logic [7:0] k;
    logic [7:0] d;
    logic       dir;
    logic       ser_in;
    logic [7:0] q;
    logic [7:0] q_n;
    logic       tc;
    logic       ser_out;

    int checks = 0;
    int errors = 0;

    jk_reg_n #(
        .WIDTH   (8),
        .RST_VAL (8'hA5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .j       (j),
        .k       (k),
        .d       (d),
        .dir     (dir),
        .ser_in  (ser_in),
        .q       (q),
        .q_n     (q_n),
        .tc      (tc),
        .ser_out (ser_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [1:0] mode;
        logic       dir;
        logic [7:0] j;
        logic [7:0] k;
        logic [7:0] d;
        logic       ser_in;
        logic [7:0] exp_q;   // q after the edge
        logic       exp_tc;  // tc before the edge
        logic       exp_so;  // ser_out before the edge
    } vec_t;

    vec_t tbl[17];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference next-state computed from the functional rules.
    function automatic logic [7:0] ref_next(input logic [7:0] cur, input logic rn, input logic e,
                                            input logic [1:0] md, input logic dr, input logic [7:0] jj,
                                            input logic [7:0] kk, input logic [7:0] dd, input logic si);
        logic [8:0] wide;
        if (!rn) return 8'hA5;
        if (!e) return cur;
        case (md)
            2'd0: return (jj & ~cur) | (~kk & cur);
            2'd1: begin
                wide = dr ? ({1'b0, cur} + 9'd1) : ({1'b0, cur} + 9'd255);
                return wide[7:0];
            end
            2'd2: begin
                if (dr) return (cur << 1) | {7'd0, si};
                else    return (cur >> 1) | (si ? 8'h80 : 8'h00);
            end
            default: return dd;
        endcase
    endfunction

    function automatic logic ref_tc(input logic [7:0] cur, input logic e, input logic [1:0] md, input logic dr);
        return e && (md == 2'd1) && (dr ? (cur == 8'hFF) : (cur == 8'h00));
    endfunction

    function automatic logic ref_so(input logic [7:0] cur, input logic dr);
        return dr ? ((cur & 8'h80) != 0) : ((cur & 8'h01) != 0);
    endfunction

    task automatic drive(input logic rn, input logic e, input logic [1:0] md, input logic dr,
                         input logic [7:0] jj, input logic [7:0] kk, input logic [7:0] dd, input logic si);
        rst_n = rn; en = e; mode = md; dir = dr; j = jj; k = kk; d = dd; ser_in = si;
    endtask

    logic [7:0] model_q;

    initial begin
        //           rst en  mode   dir   j      k      d      si    exp_q  tc    so
        tbl[0]  = '{1'b1,1'b1,2'd3,1'b0,8'h00,8'h00,8'hF0,1'b0,8'hF0,1'b0,1'b1}; // q=A5 -> load F0
        tbl[1]  = '{1'b1,1'b1,2'd0,1'b1,8'hCC,8'hAA,8'h00,1'b0,8'h5C,1'b0,1'b1}; // JK on F0
        tbl[2]  = '{1'b1,1'b1,2'd3,1'b1,8'h00,8'h00,8'hFE,1'b0,8'hFE,1'b0,1'b0};
        tbl[3]  = '{1'b1,1'b1,2'd1,1'b1,8'h00,8'h00,8'h00,1'b0,8'hFF,1'b0,1'b1}; // FE up
        tbl[4]  = '{1'b1,1'b1,2'd1,1'b1,8'h00,8'h00,8'h00,1'b0,8'h00,1'b1,1'b1}; // FF up wraps, tc
        tbl[5]  = '{1'b1,1'b1,2'd3,1'b0,8'h00,8'h00,8'h01,1'b0,8'h01,1'b0,1'b0};
        tbl[6]  = '{1'b1,1'b1,2'd1,1'b0,8'h00,8'h00,8'h00,1'b0,8'h00,1'b0,1'b1}; // 01 down
        tbl[7]  = '{1'b1,1'b1,2'd1,1'b0,8'h00,8'h00,8'h00,1'b0,8'hFF,1'b1,1'b0}; // 00 down wraps, tc
        tbl[8]  = '{1'b1,1'b1,2'd3,1'b1,8'h00,8'h00,8'h81,1'b0,8'h81,1'b0,1'b1};
        tbl[9]  = '{1'b1,1'b1,2'd2,1'b1,8'h00,8'h00,8'h00,1'b0,8'h02,1'b0,1'b1}; // shift left
        tbl[10] = '{1'b1,1'b1,2'd3,1'b0,8'h00,8'h00,8'h81,1'b0,8'h81,1'b0,1'b0};
        tbl[11] = '{1'b1,1'b1,2'd2,1'b0,8'h00,8'h00,8'h00,1'b1,8'hC0,1'b0,1'b1}; // shift right
        tbl[12] = '{1'b1,1'b0,2'd3,1'b1,8'h00,8'h00,8'h3C,1'b0,8'hC0,1'b0,1'b1}; // en=0 holds
        tbl[13] = '{1'b1,1'b0,2'd1,1'b1,8'h00,8'h00,8'h00,1'b0,8'hC0,1'b0,1'b1}; // no tc when en=0
        tbl[14] = '{1'b1,1'b1,2'd3,1'b0,8'h00,8'h00,8'h3C,1'b0,8'h3C,1'b0,1'b0}; // load 3C
        tbl[15] = '{1'b0,1'b1,2'd3,1'b1,8'h00,8'h00,8'h00,1'b0,8'hA5,1'b0,1'b0}; // reset overrides load
        tbl[16] = '{1'b1,1'b1,2'd1,1'b1,8'h00,8'h00,8'h00,1'b0,8'hA6,1'b0,1'b1}; // count from RST_VAL

        // Reset state
        drive(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        @(posedge clk); #1;
        check8("reset_q", q, 8'hA5);
        check8("reset_q_n", q_n, 8'h5A);
        check1("reset_tc", tc, 1'b0);
        check1("reset_ser_out", ser_out, 1'b1);

        // Directed table
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].rst_n, tbl[i].en, tbl[i].mode, tbl[i].dir,
                  tbl[i].j, tbl[i].k, tbl[i].d, tbl[i].ser_in);
            #1;
            check1($sformatf("vec%0d_tc", i), tc, tbl[i].exp_tc);
            check1($sformatf("vec%0d_ser_out", i), ser_out, tbl[i].exp_so);
            @(posedge clk); #1;
            check8($sformatf("vec%0d_q", i), q, tbl[i].exp_q);
            check8($sformatf("vec%0d_q_n", i), q_n, ~tbl[i].exp_q);
        end

        // Reset dropped between edges mid-count: q holds until the edge, then RST_VAL.
        drive(1'b1, 1'b1, 2'd1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
        @(posedge clk); #1;
        check8("midcount_q", q, 8'hA7);
        #2 rst_n = 1'b0;
        #1;
        check8("rst_between_edges_q", q, 8'hA7);
        check8("rst_between_edges_q_n", q_n, 8'h58);
        @(posedge clk); #1;
        check8("rst_at_edge_q", q, 8'hA5);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check8("after_release_q", q, 8'hA6);

        // Reset mid-shift with en low and shift mode: still forced to RST_VAL.
        drive(1'b1, 1'b1, 2'd2, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        @(posedge clk); #1;
        check8("midshift_q", q, 8'hD3);
        drive(1'b0, 1'b0, 2'd2, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        @(posedge clk); #1;
        check8("rst_en_low_q", q, 8'hA5);
        drive(1'b1, 1'b1, 2'd2, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        @(posedge clk); #1;
        check8("shift_after_rst_q", q, 8'h52);

        // Randomized traffic against the reference model
        model_q = 8'h52;
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            // bias toward count boundaries occasionally
            if ($urandom_range(0, 7) == 0) d = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
            #1;
            check1($sformatf("rnd%0d_tc", n), tc, ref_tc(model_q, en, mode, dir));
            check1($sformatf("rnd%0d_ser_out", n), ser_out, ref_so(model_q, dir));
            model_q = ref_next(model_q, rst_n, en, mode, dir, j, k, d, ser_in);
            @(posedge clk); #1;
            check8($sformatf("rnd%0d_q", n), q, model_q);
            check8($sformatf("rnd%0d_q_n", n), q_n, ~model_q);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
